// File: rtl/sram_fifo_pkg.sv
// rtl/sram_fifo_pkg.sv - shared constants and pointer helper for the SRAM-backed FIFO
// Purpose: output-buffer depth, SRAM read latency and the wrapping pointer increment.
package sram_fifo_pkg;

    localparam int unsigned OB_DEPTH        = 2;
    localparam int unsigned SRAM_RD_LATENCY = 1;

    // Advance a circular pointer; depth need not be a power of two.
    function automatic int unsigned ptr_incr(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/sram_fifo_obuf.sv
// rtl/sram_fifo_obuf.sv - 2-entry ordered output buffer that hides SRAM read latency
// Purpose: holds SRAM read data until popped; capture appends at the tail, pop removes the head.
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   cap, cap_data append cap_data this cycle
//   pop           remove the head entry this cycle
//   head          registered head entry
//   ob_cnt        number of entries held (0..2)
module sram_fifo_obuf
    import sram_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cap,
    input  logic [DATA_WIDTH-1:0] cap_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head,
    output logic [1:0]            ob_cnt
);

    logic [DATA_WIDTH-1:0] entry0;
    logic [DATA_WIDTH-1:0] entry1;

    assign head = entry0;

    always_ff @(posedge clk) begin
        if (rst) begin
            entry0 <= '0;
            entry1 <= '0;
            ob_cnt <= 2'd0;
        end else begin
            case ({cap, pop})
                2'b10: begin
                    if (ob_cnt == 2'd0) entry0 <= cap_data;
                    else                entry1 <= cap_data;
                    ob_cnt <= ob_cnt + 2'd1;
                end
                2'b01: begin
                    entry0 <= entry1;
                    ob_cnt <= ob_cnt - 2'd1;
                end
                2'b11: begin
                    // Head leaves and new data lands at the tail, keeping order.
                    if (ob_cnt == 2'd1) begin
                        entry0 <= cap_data;
                    end else begin
                        entry0 <= entry1;
                        entry1 <= cap_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/sram_fifo_ctrl.sv
// rtl/sram_fifo_ctrl.sv - FIFO controller driving an external 1R1W SRAM with 1-cycle read latency
// Purpose: push/pop valid-ready streams over an SRAM; a 2-entry output buffer gives 1 push + 1 pop per cycle.
// Ports:
//   clk, rst                          clock and synchronous active-high reset
//   in_valid, in_ready, in_data       push stream
//   out_valid, out_ready, out_data    pop stream (out_data registered)
//   count                             entries held: SRAM + in-flight read + output buffer
//   sram_wr, sram_wr_addr, sram_wr_din  SRAM write port
//   sram_rd, sram_rd_addr, sram_rd_dout SRAM read port (dout valid the cycle after sram_rd)
module sram_fifo_ctrl
    import sram_fifo_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH = 8,
    parameter  int unsigned DEPTH      = 2,
    localparam int unsigned ADDR_WIDTH = $clog2(DEPTH),
    localparam int unsigned CNT_WIDTH  = $clog2(DEPTH + 3)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CNT_WIDTH-1:0]  count,
    output logic                  sram_wr,
    output logic [ADDR_WIDTH-1:0] sram_wr_addr,
    output logic [DATA_WIDTH-1:0] sram_wr_din,
    output logic                  sram_rd,
    output logic [ADDR_WIDTH-1:0] sram_rd_addr,
    input  logic [DATA_WIDTH-1:0] sram_rd_dout
);

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [CNT_WIDTH-1:0]  sram_cnt;
    logic                  inflight;
    logic [1:0]            ob_cnt;
    logic [DATA_WIDTH-1:0] ob_head;
    logic                  push;
    logic                  pop;
    logic                  rd_issue;
    logic [2:0]            ob_pending;

    assign in_ready  = !rst && (sram_cnt < CNT_WIDTH'(DEPTH));
    assign push      = in_valid && in_ready;
    assign out_valid = !rst && (ob_cnt != 2'd0);
    assign pop       = out_valid && out_ready;

    // Issue only when the buffer will have room for the returning word,
    // counting the read already in flight and any pop this cycle.
    // Issue uses registered sram_cnt, so a word written this cycle is
    // never read in the same cycle.
    assign ob_pending = {1'b0, ob_cnt} + {2'b00, inflight};
    assign rd_issue   = !rst && (sram_cnt != '0) &&
                        (ob_pending < (3'(OB_DEPTH) + {2'b00, pop}));

    assign sram_wr      = push;
    assign sram_wr_addr = wr_ptr;
    assign sram_wr_din  = in_data;
    assign sram_rd      = rd_issue;
    assign sram_rd_addr = rd_ptr;

    assign out_data = rst ? '0 : ob_head;
    assign count    = rst ? '0 : (sram_cnt + CNT_WIDTH'(inflight) + CNT_WIDTH'(ob_cnt));

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            sram_cnt <= '0;
            inflight <= 1'b0;
        end else begin
            if (push)     wr_ptr <= ADDR_WIDTH'(ptr_incr(32'(wr_ptr), DEPTH));
            if (rd_issue) rd_ptr <= ADDR_WIDTH'(ptr_incr(32'(rd_ptr), DEPTH));
            sram_cnt <= sram_cnt + CNT_WIDTH'(push) - CNT_WIDTH'(rd_issue);
            // Read data returns SRAM_RD_LATENCY (one) cycle after issue.
            inflight <= rd_issue;
        end
    end

    // A read in flight during reset is dropped: inflight is forced low
    // while rst is high, and the buffer itself is cleared.
    sram_fifo_obuf #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_obuf (
        .clk      (clk),
        .rst      (rst),
        .cap      (inflight && !rst),
        .cap_data (sram_rd_dout),
        .pop      (pop),
        .head     (ob_head),
        .ob_cnt   (ob_cnt)
    );

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// tb/tb_sram_fifo_ctrl.sv - self-checking bench for sram_fifo_ctrl at DEPTH=4 and DEPTH=3
module tb_sram_fifo_ctrl;

    localparam int D0 = 4;
    localparam int D1 = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       in_valid     [2];
    logic       out_ready    [2];
    logic [7:0] in_data      [2];
    logic       in_ready     [2];
    logic       out_valid    [2];
    logic       sram_wr      [2];
    logic       sram_rd      [2];
    logic [7:0] out_data     [2];
    logic [7:0] sram_wr_din  [2];
    logic [7:0] sram_rd_dout [2];
    logic [1:0] sram_wr_addr [2];
    logic [1:0] sram_rd_addr [2];
    logic [2:0] count        [2];
    logic [7:0] mem          [2][4];

    int n_vec = 0;
    int n_fail = 0;
    int acc [2];
    int popped [2];
    int wa [2];
    int ra [2];
    logic [7:0] sb0 [$];
    logic [7:0] sb1 [$];

    sram_fifo_ctrl #(.DATA_WIDTH(8), .DEPTH(D0)) u_d4 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
        .count(count[0]),
        .sram_wr(sram_wr[0]), .sram_wr_addr(sram_wr_addr[0]), .sram_wr_din(sram_wr_din[0]),
        .sram_rd(sram_rd[0]), .sram_rd_addr(sram_rd_addr[0]), .sram_rd_dout(sram_rd_dout[0])
    );

    sram_fifo_ctrl #(.DATA_WIDTH(8), .DEPTH(D1)) u_d3 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
        .count(count[1]),
        .sram_wr(sram_wr[1]), .sram_wr_addr(sram_wr_addr[1]), .sram_wr_din(sram_wr_din[1]),
        .sram_rd(sram_rd[1]), .sram_rd_addr(sram_rd_addr[1]), .sram_rd_dout(sram_rd_dout[1])
    );

    // 1R1W SRAM model with registered read
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (sram_wr[i]) mem[i][sram_wr_addr[i]] <= sram_wr_din[i];
            if (sram_rd[i]) sram_rd_dout[i] <= mem[i][sram_rd_addr[i]];
        end
    end

    task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[d%0d]: got %0h, expected %0h", name, (inst == 0) ? D0 : D1, act, exp);
        end
    endtask

    function automatic int sb_size(input int i);
        return (i == 0) ? sb0.size() : sb1.size();
    endfunction

    task automatic sb_push(input int i, input logic [7:0] d);
        if (i == 0) sb0.push_back(d);
        else        sb1.push_back(d);
    endtask

    function automatic logic [7:0] sb_pop(input int i);
        if (i == 0) return sb0.pop_front();
        return sb1.pop_front();
    endfunction

    task automatic sb_clear(input int i);
        if (i == 0) sb0.delete();
        else        sb1.delete();
    endtask

    // Scoreboard monitor, sampled on the falling edge
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int lim;
            lim = (i == 0) ? D0 : D1;
            if (rst) begin
                chk("rst_in_ready",  i, 32'(in_ready[i]),  32'd0);
                chk("rst_out_valid", i, 32'(out_valid[i]), 32'd0);
                chk("rst_sram_wr",   i, 32'(sram_wr[i]),   32'd0);
                chk("rst_sram_rd",   i, 32'(sram_rd[i]),   32'd0);
                chk("rst_out_data",  i, 32'(out_data[i]),  32'd0);
                chk("rst_count",     i, 32'(count[i]),     32'd0);
                sb_clear(i);
                wa[i] = 0;
                ra[i] = 0;
            end else begin
                chk("count_occ", i, 32'(count[i]), 32'(sb_size(i)));
                chk("count_max", i, (32'(count[i]) <= 32'(lim + 2)) ? 32'd1 : 32'd0, 32'd1);
                chk("wr_en", i, 32'(sram_wr[i]), 32'(in_valid[i] && in_ready[i]));
                if (sram_wr[i]) begin
                    chk("wr_addr", i, 32'(sram_wr_addr[i]), 32'(wa[i]));
                    chk("wr_din",  i, 32'(sram_wr_din[i]),  32'(in_data[i]));
                    wa[i] = (wa[i] == lim - 1) ? 0 : wa[i] + 1;
                end
                if (sram_rd[i]) begin
                    chk("rd_addr", i, 32'(sram_rd_addr[i]), 32'(ra[i]));
                    ra[i] = (ra[i] == lim - 1) ? 0 : ra[i] + 1;
                end
                if (out_valid[i] && out_ready[i]) begin
                    if (sb_size(i) == 0) chk("pop_underflow", i, 32'd1, 32'd0);
                    else                 chk("pop_data", i, 32'(out_data[i]), 32'(sb_pop(i)));
                    popped[i]++;
                end
                if (in_valid[i] && in_ready[i]) begin
                    sb_push(i, in_data[i]);
                    acc[i]++;
                end
            end
        end
    end

    typedef struct {
        logic       iv;
        logic [7:0] d;
        logic       ordy;
        logic       e_ir;
        logic       e_wr;
        logic       e_rd;
        logic [1:0] e_ra;
        logic       e_ov;
        logic [7:0] e_od;
        logic [2:0] e_cnt;
    } vec_t;

    vec_t tbl [5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_valid[i] = 1'b0; out_ready[i] = 1'b0; in_data[i] = 8'h00;
        end
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            acc[i] = 0; popped[i] = 0;
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            in_valid[i] = 1'b0; out_ready[i] = 1'b0; in_data[i] = 8'h00;
            acc[i] = 0; popped[i] = 0; wa[i] = 0; ra[i] = 0;
        end

        //          iv    d      ordy  ir    wr    rd    ra    ov    od     cnt
        tbl[0] = '{1'b1, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 8'h00, 3'd0};
        tbl[1] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 8'h00, 3'd1};
        tbl[2] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 8'h00, 3'd1};
        tbl[3] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 8'hA5, 3'd1};
        tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 8'h00, 3'd0};

        // Single push latency
        do_reset();
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < 2; i++) begin
                in_valid[i] = tbl[k].iv; in_data[i] = tbl[k].d; out_ready[i] = tbl[k].ordy;
            end
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                chk("tbl_in_ready",  i, 32'(in_ready[i]),  32'(tbl[k].e_ir));
                chk("tbl_sram_wr",   i, 32'(sram_wr[i]),   32'(tbl[k].e_wr));
                chk("tbl_sram_rd",   i, 32'(sram_rd[i]),   32'(tbl[k].e_rd));
                if (tbl[k].e_rd) chk("tbl_rd_addr", i, 32'(sram_rd_addr[i]), 32'(tbl[k].e_ra));
                chk("tbl_out_valid", i, 32'(out_valid[i]), 32'(tbl[k].e_ov));
                if (tbl[k].e_ov) chk("tbl_out_data", i, 32'(out_data[i]), 32'(tbl[k].e_od));
                chk("tbl_count",     i, 32'(count[i]),     32'(tbl[k].e_cnt));
            end
            tick();
        end

        // Fill to DEPTH+2 with out_ready low, then drain
        do_reset();
        for (int c = 0; c < 12; c++) begin
            for (int i = 0; i < 2; i++) begin
                in_valid[i] = 1'b1; out_ready[i] = 1'b0; in_data[i] = 8'(acc[i] + 1);
            end
            @(negedge clk);
            tick();
        end
        @(negedge clk);
        chk("full_accepted", 0, 32'(acc[0]), 32'(D0 + 2));
        chk("full_accepted", 1, 32'(acc[1]), 32'(D1 + 2));
        chk("full_in_ready", 0, 32'(in_ready[0]), 32'd0);
        chk("full_in_ready", 1, 32'(in_ready[1]), 32'd0);
        chk("full_count", 0, 32'(count[0]), 32'(D0 + 2));
        chk("full_count", 1, 32'(count[1]), 32'(D1 + 2));
        tick();
        for (int i = 0; i < 2; i++) begin
            in_valid[i] = 1'b0; out_ready[i] = 1'b1;
        end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            tick();
        end
        chk("drain_popped", 0, 32'(popped[0]), 32'(D0 + 2));
        chk("drain_popped", 1, 32'(popped[1]), 32'(D1 + 2));

        // Continuous stream: 0..99 out on cycles 3..102, no bubbles
        do_reset();
        for (int c = 0; c < 110; c++) begin
            for (int i = 0; i < 2; i++) begin
                in_valid[i] = (c < 100); in_data[i] = 8'(c); out_ready[i] = 1'b1;
            end
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (c >= 3 && c <= 102) begin
                    chk("stream_valid", i, 32'(out_valid[i]), 32'd1);
                    chk("stream_data",  i, 32'(out_data[i]),  32'(c - 3));
                end else if (c == 103) begin
                    chk("stream_end", i, 32'(out_valid[i]), 32'd0);
                end
            end
            tick();
        end

        // 20 items with alternating out_ready; pointer wrap checked by the monitor
        do_reset();
        for (int c = 0; c < 300 && (popped[0] < 20 || popped[1] < 20); c++) begin
            for (int i = 0; i < 2; i++) begin
                in_valid[i] = (acc[i] < 20); in_data[i] = 8'(acc[i] + 100); out_ready[i] = c[0];
            end
            @(negedge clk);
            tick();
        end
        chk("alt_popped", 0, 32'(popped[0]), 32'd20);
        chk("alt_popped", 1, 32'(popped[1]), 32'd20);

        // Random valid/ready, 1000 items per instance
        do_reset();
        for (int c = 0; c < 8000 && (popped[0] < 1000 || popped[1] < 1000); c++) begin
            for (int i = 0; i < 2; i++) begin
                in_valid[i]  = (acc[i] < 1000) && ($urandom_range(1) == 1);
                in_data[i]   = 8'($urandom_range(255));
                out_ready[i] = ($urandom_range(1) == 1);
            end
            @(negedge clk);
            tick();
        end
        chk("rand_popped", 0, 32'(popped[0]), 32'd1000);
        chk("rand_popped", 1, 32'(popped[1]), 32'd1000);

        // Reset with a read in flight
        do_reset();
        for (int i = 0; i < 2; i++) begin
            in_valid[i] = 1'b1; in_data[i] = 8'h11; out_ready[i] = 1'b0;
        end
        @(negedge clk);
        tick();
        for (int i = 0; i < 2; i++) in_data[i] = 8'h22;
        @(negedge clk);
        for (int i = 0; i < 2; i++) chk("mid_rd_c1", i, 32'(sram_rd[i]), 32'd1);
        tick();
        for (int i = 0; i < 2; i++) in_data[i] = 8'h33;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("mid_rd_c2",    i, 32'(sram_rd[i]), 32'd1);
            chk("mid_count_c2", i, 32'(count[i]),   32'd2);
        end
        tick();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) in_valid[i] = 1'b0;
        @(negedge clk);
        tick();
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("post_rst_count", i, 32'(count[i]),     32'd0);
            chk("post_rst_valid", i, 32'(out_valid[i]), 32'd0);
        end
        tick();
        for (int i = 0; i < 2; i++) begin
            in_valid[i] = 1'b1; in_data[i] = 8'h3C; out_ready[i] = 1'b1;
        end
        @(negedge clk);
        tick();
        for (int i = 0; i < 2; i++) in_valid[i] = 1'b0;
        begin
            bit found;
            found = 1'b0;
            for (int k = 0; k < 10 && !found; k++) begin
                @(negedge clk);
                if (out_valid[0] || out_valid[1]) begin
                    found = 1'b1;
                    for (int i = 0; i < 2; i++) begin
                        chk("post_rst_first_valid", i, 32'(out_valid[i]), 32'd1);
                        chk("post_rst_first_data",  i, 32'(out_data[i]),  32'h3C);
                    end
                end
                tick();
            end
            chk("post_rst_timeout", 0, 32'(found), 32'd1);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/sram_fifo_ctrl.md
Name: sram_fifo_ctrl

Overview:
- Synchronous FIFO controller that drives an external 1R1W SRAM macro through its write and read ports.
- The SRAM has a registered read with 1-cycle latency.
- Presents valid/ready streams on both the push side and the pop side.
- A 2-entry output buffer hides SRAM read latency, so the FIFO sustains one push and one pop per cycle. It is the read/write initiator paired with the SRAM macro in buffer paths.

Parameters:
- DATA_WIDTH, 8, payload width; must match the SRAM.
- DEPTH, 2, SRAM entries; minimum 2; need not be a power of two.
- ADDR_WIDTH, $clog2(DEPTH), localparam; SRAM address width.
- CNT_WIDTH, $clog2(DEPTH+3), localparam; width of the occupancy output.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  push request
- in_ready  out  1  push accepted when in_valid && in_ready
- in_data  in  DATA_WIDTH  push payload
- out_valid  out  1  head entry valid
- out_ready  in  1  pop when out_valid && out_ready
- out_data  out  DATA_WIDTH  head payload
- count  out  CNT_WIDTH  total entries held
- sram_wr  out  1  SRAM write enable
- sram_wr_addr  out  ADDR_WIDTH  SRAM write address
- sram_wr_din  out  DATA_WIDTH  SRAM write data
- sram_rd  out  1  SRAM read enable
- sram_rd_addr  out  ADDR_WIDTH  SRAM read address
- sram_rd_dout  in  DATA_WIDTH  SRAM read data, valid the cycle after sram_rd

Behaviour:
- Interface: one clock, clk; reset rst is synchronous, active-high.
- State: wr_ptr, rd_ptr (0..DEPTH-1); sram_cnt (0..DEPTH); inflight flag; 2-entry output buffer ob with ob_cnt (0..2).
- Reset (sampled rst=1): pointers, sram_cnt, inflight and ob_cnt cleared to 0. While rst=1, in_ready, out_valid, sram_wr and sram_rd are all 0, out_data=0, count=0.
- Reset mid-operation: a read in flight at reset is discarded. Its sram_rd_dout is never captured.
- Push:
  - in_ready = (sram_cnt < DEPTH), using registered sram_cnt.
  - On a push, sram_wr=1 in the same cycle, with sram_wr_addr=wr_ptr and sram_wr_din=in_data (combinational).
  - wr_ptr advances, wrapping DEPTH-1 -> 0.
- Read issue:
  - pop = out_valid && out_ready.
  - sram_rd=1 when sram_cnt>0 && (ob_cnt + inflight - pop) < 2, with sram_rd_addr=rd_ptr.
  - rd_ptr wraps the same way as wr_ptr.
  - inflight is set for the next cycle.
- Collision rule: read issue uses registered sram_cnt, so an entry written in cycle t is readable from t+1 at the earliest. Read and write addresses never coincide for live data.
- sram_cnt next value = sram_cnt + push - rd_issue. A simultaneous push and read leaves it unchanged.
- Capture: when inflight=1, sram_rd_dout is appended to ob that cycle. ob is never overfull, guaranteed by the issue rule.
- Pop:
  - out_valid = (ob_cnt > 0); out_data = ob head.
  - Capture and pop in the same cycle keep order: head shifts, new data goes to the tail.
- count = sram_cnt + inflight + ob_cnt. Maximum is DEPTH+2 when out_ready is held 0.
- Latency, empty FIFO: push accepted in cycle t -> sram_rd in t+1 -> capture in t+2 -> out_valid=1 in t+3.
- Throughput: steady state is 1 push and 1 pop per cycle with no bubbles.
- out_data is registered. There is no combinational path from sram_rd_dout to out_data.

Decomposition:
- Package sram_fifo_pkg holds:
  - OB_DEPTH=2
  - SRAM_RD_LATENCY=1
  - a ptr_incr wrap function parameterised by DEPTH
- One sub-module, sram_fifo_obuf: the 2-entry ordered output buffer with capture/pop inputs and ob_cnt out.
- Pointer, count and issue logic stay in the top module.
- The SRAM macro is instantiated outside this block; the testbench connects it.

Test Plan:
- Reset, then push 0xA5 at cycle 0 with out_ready=1 -> sram_wr at cycle 0, sram_rd addr 0 at cycle 1, out_valid with 0xA5 at cycle 3, count back to 0 at cycle 4.
- DEPTH=4, out_ready=0, in_valid held high with data 1,2,3... -> exactly 6 pushes accepted, then in_ready=0 and count=6; then popping yields 1..6 in order.
- DEPTH=4, continuous push of 0..99 with out_ready=1 -> 0..99 popped in order, one per cycle, from cycle 3 through 102, no bubbles.
- DEPTH=3 (non-power-of-two), 20 items with alternating out_ready -> pointers wrap 2->0 correctly, data in order, no loss or duplication.
- Random in_valid and out_ready (50%), 1000 items checked against a reference queue -> in-order match, count always equals the model occupancy, count never exceeds DEPTH+2.
- Assert rst one cycle after an sram_rd issue with 3 entries held -> next cycle count=0 and out_valid=0; the discarded read data never appears on out_data; a subsequent push of 0x3C emerges as the first output.
